// File: rtl/encoder83_pending_if.sv
// Request/handshake bundle for the pending 8-to-3 encoder.
// slave is the encoder side; master is the request source plus code consumer.
interface encoder83_pending_if;
    logic       e;
    logic [7:0] w;
    logic [2:0] y;
    logic       valid;
    logic       ready;
    logic [7:0] pend;
    logic       overflow;

    modport master (output e, w, ready, input y, valid, pend, overflow);
    modport slave  (input e, w, ready, output y, valid, pend, overflow);
endinterface

// File: rtl/encoder83_pending.sv
// Latches request strobes into a pending vector and serves them one code per
// valid/ready handshake, highest index first.
//
// state | meaning
// IDLE  | no code on offer, valid=0
// HOLD  | y carries a pending line, valid=1, waiting for ready
module encoder83_pending (
    input  logic                      clk,
    input  logic                      rst_n,
    encoder83_pending_if.slave        bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t     state_q, state_nxt;
    logic [7:0] pend_q, pend_nxt;
    logic [2:0] y_q, y_nxt;
    logic       ovf_q, ovf_nxt;

    logic       take;
    logic [7:0] clr;
    logic [7:0] set;
    logic [7:0] remain;

    function automatic logic [2:0] sel(input logic [7:0] x);
        sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) sel = 3'(i);
        end
    endfunction

    assign take   = (state_q == HOLD) && bus.ready;
    assign clr    = take ? (8'd1 << y_q) : 8'd0;
    assign set    = bus.e ? bus.w : 8'd0;
    assign remain = pend_q & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= 8'd0;
            y_q     <= 3'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            pend_q  <= pend_nxt;
            y_q     <= y_nxt;
            ovf_q   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (pend_q != 8'd0) state_nxt = HOLD;
            HOLD:    if (take && (remain == 8'd0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Selection only looks at registered pending bits; same-cycle arrivals
    // become visible one cycle later.
    always_comb begin
        y_nxt    = y_q;
        pend_nxt = remain | set;
        ovf_nxt  = |(set & remain);
        case (state_q)
            IDLE:    if (pend_q != 8'd0) y_nxt = sel(pend_q);
            HOLD:    if (take && (remain != 8'd0)) y_nxt = sel(remain);
            default: y_nxt = y_q;
        endcase
    end

    assign bus.y        = y_q;
    assign bus.valid    = (state_q == HOLD);
    assign bus.pend     = pend_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_encoder83_pending.sv
// Self-checking bench for encoder83_pending: directed scenarios plus random
// traffic compared against a behavioural pending-list model.
module tb_encoder83_pending;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    encoder83_pending_if ifc();

    encoder83_pending dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: set of pending line numbers, the code on offer and the overflow flag.
    bit       m_pend [8];
    bit       m_valid;
    bit [2:0] m_y;
    bit       m_ovf;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
        m_valid = 1'b0;
        m_y     = 3'd0;
        m_ovf   = 1'b0;
    endfunction

    function automatic int highest(input bit v [8]);
        highest = -1;
        for (int i = 7; i >= 0; i--) begin
            if (v[i] && highest < 0) highest = i;
        end
    endfunction

    function automatic void model_step(input bit ee, input logic [7:0] ww, input bit rr);
        bit left [8];
        bit newreq [8];
        bit accepted;
        int h;
        accepted = m_valid && rr;
        m_ovf = 1'b0;
        for (int i = 0; i < 8; i++) begin
            left[i]   = m_pend[i] && !(accepted && i == int'(m_y));
            newreq[i] = ee && ww[i];
            if (newreq[i] && left[i]) m_ovf = 1'b1;
        end
        if (!m_valid) begin
            h = highest(m_pend);
            if (h >= 0) begin
                m_valid = 1'b1;
                m_y = 3'(h);
            end
        end else if (accepted) begin
            h = highest(left);
            if (h >= 0) m_y = 3'(h);
            else m_valid = 1'b0;
        end
        for (int i = 0; i < 8; i++) m_pend[i] = left[i] || newreq[i];
    endfunction

    function automatic logic [12:0] expv();
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = m_pend[i];
        return {m_y, m_valid, p, m_ovf};
    endfunction

    function automatic logic [12:0] obsv();
        return {ifc.y, ifc.valid, ifc.pend, ifc.overflow};
    endfunction

    task automatic cycle(input bit ee, input logic [7:0] ww, input bit rr);
        ifc.e = ee; ifc.w = ww; ifc.ready = rr;
        @(posedge clk);
        model_step(ee, ww, rr);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ifc.e = 1'b1; ifc.w = 8'hFF; ifc.ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obsv() !== 13'd0) $display("FAIL reset_state got=%h want=%h", obsv(), 13'd0);
        else n_pass++;
        rst_n = 1'b1;
        cycle(1'b1, 8'h00, 1'b0);
        n_checks++;
        if (ifc.valid !== 1'b0 || ifc.pend !== 8'h00)
            $display("FAIL reset_release got valid=%b pend=%h want valid=0 pend=00", ifc.valid, ifc.pend);
        else n_pass++;
    endtask

    task automatic test_single();
        cycle(1'b1, 8'h20, 1'b0);
        n_checks++;
        if (ifc.pend !== 8'h20 || ifc.valid !== 1'b0)
            $display("FAIL single_latch got pend=%h valid=%b want pend=20 valid=0", ifc.pend, ifc.valid);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 8'h00, 1'b0);
            n_checks++;
            if (ifc.valid !== 1'b1 || ifc.y !== 3'd5)
                $display("FAIL single_hold%0d got valid=%b y=%0d want valid=1 y=5", k, ifc.valid, ifc.y);
            else n_pass++;
        end
        cycle(1'b1, 8'h00, 1'b1);
        n_checks++;
        if (ifc.valid !== 1'b0 || ifc.pend !== 8'h00 || obsv() !== expv())
            $display("FAIL single_accept got %h want %h", obsv(), expv());
        else n_pass++;
    endtask

    task automatic test_priority_drain();
        logic [2:0] seq [4];
        seq[0] = 3'd7; seq[1] = 3'd4; seq[2] = 3'd2; seq[3] = 3'd1;
        cycle(1'b1, 8'b1001_0110, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 8'h00, 1'b1);
            n_checks++;
            if (ifc.valid !== 1'b1 || ifc.y !== seq[k])
                $display("FAIL drain%0d got valid=%b y=%0d want valid=1 y=%0d", k, ifc.valid, ifc.y, seq[k]);
            else n_pass++;
        end
        cycle(1'b1, 8'h00, 1'b1);
        n_checks++;
        if (ifc.valid !== 1'b0 || ifc.pend !== 8'h00)
            $display("FAIL drain_end got valid=%b pend=%h want valid=0 pend=00", ifc.valid, ifc.pend);
        else n_pass++;
    endtask

    task automatic test_no_preempt();
        int served7;
        cycle(1'b1, 8'h08, 1'b0);
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b1, 8'h80, 1'b0);
        n_checks++;
        if (ifc.y !== 3'd3 || ifc.overflow !== 1'b0)
            $display("FAIL preempt_first got y=%0d ovf=%b want y=3 ovf=0", ifc.y, ifc.overflow);
        else n_pass++;
        cycle(1'b1, 8'h80, 1'b0);
        n_checks++;
        if (ifc.y !== 3'd3 || ifc.overflow !== 1'b1)
            $display("FAIL preempt_dup got y=%0d ovf=%b want y=3 ovf=1", ifc.y, ifc.overflow);
        else n_pass++;
        cycle(1'b1, 8'h00, 1'b0);
        n_checks++;
        if (ifc.overflow !== 1'b0 || ifc.pend !== 8'h88)
            $display("FAIL ovf_pulse got ovf=%b pend=%h want ovf=0 pend=88", ifc.overflow, ifc.pend);
        else n_pass++;
        served7 = 0;
        for (int k = 0; k < 6; k++) begin
            if (ifc.valid && ifc.y == 3'd7) served7++;
            cycle(1'b1, 8'h00, 1'b1);
        end
        n_checks++;
        if (served7 != 1 || ifc.valid !== 1'b0)
            $display("FAIL merge_once got served7=%0d valid=%b want served7=1 valid=0", served7, ifc.valid);
        else n_pass++;
    endtask

    task automatic test_enable_gating();
        cycle(1'b1, 8'h03, 1'b0);
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b0, 8'hFF, 1'b0);
        n_checks++;
        if (ifc.pend !== 8'h03 || ifc.overflow !== 1'b0 || ifc.y !== 3'd1)
            $display("FAIL gate_block got pend=%h ovf=%b y=%0d want pend=03 ovf=0 y=1", ifc.pend, ifc.overflow, ifc.y);
        else n_pass++;
        for (int k = 0; k < 10 && ifc.valid; k++) cycle(1'b0, 8'hFF, 1'b1);
        n_checks++;
        if (ifc.valid !== 1'b0 || ifc.pend !== 8'h00 || obsv() !== expv())
            $display("FAIL gate_drain got %h want %h", obsv(), expv());
        else n_pass++;
    endtask

    task automatic test_collision_async_reset();
        cycle(1'b1, 8'h10, 1'b0);
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b1, 8'h10, 1'b1);
        n_checks++;
        if (ifc.pend !== 8'h10 || ifc.overflow !== 1'b0 || ifc.valid !== 1'b0)
            $display("FAIL collision got pend=%h ovf=%b valid=%b want pend=10 ovf=0 valid=0", ifc.pend, ifc.overflow, ifc.valid);
        else n_pass++;
        cycle(1'b1, 8'h00, 1'b0);
        n_checks++;
        if (ifc.valid !== 1'b1 || ifc.y !== 3'd4)
            $display("FAIL collision_reserve got valid=%b y=%0d want valid=1 y=4", ifc.valid, ifc.y);
        else n_pass++;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (ifc.valid !== 1'b0 || ifc.pend !== 8'h00 || ifc.y !== 3'd0)
            $display("FAIL async_reset got valid=%b pend=%h y=%0d want valid=0 pend=00 y=0", ifc.valid, ifc.pend, ifc.y);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        bit ee, rr;
        logic [7:0] ww;
        int bad;
        bad = 0;
        for (int k = 0; k < 400; k++) begin
            ee = ($urandom_range(0, 3) != 0);
            ww = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            rr = 1'($urandom_range(0, 1));
            cycle(ee, ww, rr);
            n_checks++;
            if (obsv() !== expv()) begin
                bad++;
                if (bad < 10) $display("FAIL random%0d got %h want %h", k, obsv(), expv());
            end else n_pass++;
        end
        for (int k = 0; k < 12; k++) cycle(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (obsv() !== expv() || ifc.valid !== 1'b0)
            $display("FAIL random_drain got %h want %h", obsv(), expv());
        else n_pass++;
    endtask

    initial begin
        ifc.e = 1'b0; ifc.w = 8'h00; ifc.ready = 1'b0;
        #2;
        test_reset();
        test_single();
        test_priority_drain();
        test_no_preempt();
        test_enable_gating();
        test_collision_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/encoder83_pending.md
# encoder83_pending

Sequential 8-to-3 priority encoder with request latching and a valid/ready output handshake. It is the inverse of the 3-to-8 active-high decoders: it captures active-high request strobes on an 8-bit line vector and emits the 3-bit index of each pending line, one code per handshake. It sits between event sources (interrupt-style strobes) and a consumer that drives the decoder tree back from the code.

## Interface
- N, 8, number of request lines; fixed at 8 for this block.
- CW, 3, code width; equals log2(N).

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- e  input  1  active-high enable. When 0, `w` is ignored.
- w  input  8  request strobes, active high, sampled every clock while `e`=1.
- y  output  3  encoded index of the line being served. Stable while `valid`=1 and `ready`=0.
- valid  output  1  `y` holds a pending request.
- ready  input  1  consumer accepts `y` when `valid`&`ready`.
- pend  output  8  registered pending vector P.
- overflow  output  1  one-cycle pulse. A request arrived on a line that was already pending and was not being cleared.

## Operation
- Pending register P[7:0]. Per clock:
  - `take` = `valid & ready`.
  - `clr` = onehot(`y`) when `take`, else 0.
  - `set` = `e ? w : 0`.
  - P_next = (P & ~`clr`) | `set`. Set wins over clear on the same bit, so the line is re-pended as a new event.
- Remaining vector R = P & ~`clr`. Selection function sel(X) returns the highest set index of X (bit 7 has highest priority).
- Output state machine, two states:
  - IDLE (`valid`=0): if P≠0, load `y`=sel(P), set `valid`=1, go HOLD. Otherwise stay.
  - HOLD (`valid`=1): if `take`=0, hold `y` and `valid`. A higher-priority arrival does not preempt.
  - HOLD with `take`=1:
    - if R≠0, load `y`=sel(R) and keep `valid`=1. Back-to-back, no bubble.
    - if R=0, set `valid`=0 and go IDLE.
    - `set` bits arriving in the same cycle are not visible to selection until the next cycle.
- `overflow`_next = |(`set` & P & ~`clr`). It is registered, and each event gives a single pulse. The request is merged; it is not counted twice.
- `e`=0 blocks new requests only. Pending lines keep draining normally.
- `w`=0 with `e`=1 has no effect.
- `y` keeps its last value when `valid`=0. Consumers must ignore it.

## Timing
- Reset (`rst_n`=0, asynchronous): P=0, `pend`=0, `y`=3'b000, `valid`=0, `overflow`=0, state IDLE. Release is synchronous to the next `clk` edge. There are no partial results after reset mid-operation: everything is cleared, including the code in flight.
- Latency: a strobe sampled at edge k sets P after edge k. `valid` rises after edge k+1 (2 cycles from `w` to `valid`).
- Throughput: one code per cycle while `ready`=1 and requests remain pending.
- `overflow` is asserted for exactly the one cycle following the edge that sampled the duplicate request.
- All outputs are registered. There is no combinational path from `w`/`e`/`ready` to any output.

## Test plan
- Reset: hold `rst_n`=0 with `w`=8'hFF, `e`=1 → `y`=0, `valid`=0, `pend`=0, `overflow`=0. After release, one cycle with `w`=8'h00 keeps `valid`=0.
- Single request: `e`=1, `w`=8'h20 for one cycle, `ready`=0 → `pend`=8'h20 after edge k, `valid`=1 with `y`=5 after edge k+1. `y` holds for 5 cycles. Then `ready`=1 → `valid`=0 and `pend`=0 on the next edge.
- Priority drain: `w`=8'b1001_0110 for one cycle, `ready`=1 continuously → `y` sequence 7,4,2,1 on consecutive cycles with `valid` continuous, then `valid`=0.
- No preemption / merge: serving `y`=3 with `ready`=0, apply `w`=8'h80 then `w`=8'h80 again → `y` stays 3. `overflow` pulses once, after the second strobe. After handshake `y`=7 is served once only.
- Enable gating: `e`=0, `w`=8'hFF → `pend` is unchanged and `overflow`=0. Existing pending lines still drain.
- Set/clear collision and async reset: `y`=4 accepted in the same cycle that `w`=8'h10 arrives → bit 4 stays pending and `overflow`=0. Later, drop `rst_n` mid-HOLD between edges → `valid` and `pend` go to 0 immediately.
